// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder constants and pixel/row types.
package jpeg_dec_pkg;
    localparam int DATA_W         = 32;
    localparam int SHIFT_W        = 5;
    localparam int PIX_W          = 8;
    localparam int ROW_PIX        = 8;
    localparam int LEVEL_OFFSET   = 128;
    localparam int ROWS_PER_BLOCK = 8;
    localparam int ROW_W          = PIX_W * ROW_PIX;
    localparam int PACK_W         = PIX_W * (ROW_PIX - 1);
    localparam int COL_W          = $clog2(ROW_PIX);

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [PACK_W-1:0] pack_t;
endpackage

// File: rtl/descale_clamp_unit.sv
// Combinational descale datapath: round-add + arithmetic shift (S1 side) and
// level shift + clamp to 0..255 (S2 side).
module descale_clamp_unit
    import jpeg_dec_pkg::*;
#(
    parameter int DATA_W       = jpeg_dec_pkg::DATA_W,
    parameter int SHIFT_W      = jpeg_dec_pkg::SHIFT_W,
    parameter int LEVEL_OFFSET = jpeg_dec_pkg::LEVEL_OFFSET
) (
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [DATA_W:0]    scaled_o,
    input  logic [DATA_W:0]    scaled_i,
    output pix_t               pix_o,
    output logic               clamped_o
);
    logic [DATA_W:0]   rnd;
    logic [DATA_W:0]   sum;
    logic [DATA_W+1:0] lvl;

    always_comb begin
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (DATA_W+1)'(1) << (shift_i - 1'b1);
        end
        // One extra bit keeps the rounding add from overflowing at full-scale input.
        sum      = {data_i[DATA_W-1], data_i} + rnd;
        scaled_o = $signed(sum) >>> shift_i;

        lvl       = {scaled_i[DATA_W], scaled_i} + (DATA_W+2)'(LEVEL_OFFSET);
        pix_o     = lvl[PIX_W-1:0];
        clamped_o = 1'b0;
        if (lvl[DATA_W+1]) begin
            pix_o     = '0;
            clamped_o = 1'b1;
        end else if (|lvl[DATA_W:PIX_W]) begin
            pix_o     = '1;
            clamped_o = 1'b1;
        end
    end
endmodule

// File: rtl/idct_descale_packer.sv
// Descales IDCT samples to 8-bit pixels and packs them into 64-bit rows with
// end-of-block marking. Optional saturation counter under DESCALE_SAT_COUNT_EN.
module idct_descale_packer
    import jpeg_dec_pkg::*;
#(
    parameter int DATA_W         = jpeg_dec_pkg::DATA_W,
    parameter int SHIFT_W        = jpeg_dec_pkg::SHIFT_W,
    parameter int LEVEL_OFFSET   = jpeg_dec_pkg::LEVEL_OFFSET,
    parameter int ROWS_PER_BLOCK = jpeg_dec_pkg::ROWS_PER_BLOCK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROW_W-1:0]   out_row,
    output logic               out_last
`ifdef DESCALE_SAT_COUNT_EN
   ,input  logic               sat_clear,
    output logic [15:0]        sat_count
`endif
);
    localparam int ROW_CW = $clog2(ROWS_PER_BLOCK);

    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W:0]    s1_data_q, s1_data_d;
    logic [COL_W-1:0]   s1_col_q, s1_col_d;
    logic [ROW_CW-1:0]  s1_row_q, s1_row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_CW-1:0]  row_q, row_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    pack_t              pack_q, pack_d;
    logic               out_valid_q, out_valid_d;
    row_t               out_row_q, out_row_d;
    logic               out_last_q, out_last_d;

    logic               out_free, s1_last_col, s1_adv, s1_take, in_fire, block_start;
    logic [SHIFT_W-1:0] eff_shift;
    logic [DATA_W:0]    scaled;
    pix_t               pix;
    logic               clamped;

    assign out_free    = !out_valid_q || out_ready;
    assign s1_last_col = (s1_col_q == COL_W'(ROW_PIX - 1));
    assign s1_adv      = !s1_last_col || out_free;
    assign s1_take     = s1_valid_q && s1_adv;
    assign in_ready    = !s1_valid_q || s1_adv;
    assign in_fire     = in_valid && in_ready;
    assign block_start = (col_q == '0) && (row_q == '0);
    // The first sample of a block already uses the shift it latches.
    assign eff_shift   = block_start ? shift_amt : shift_q;

    descale_clamp_unit #(
        .DATA_W       (DATA_W),
        .SHIFT_W      (SHIFT_W),
        .LEVEL_OFFSET (LEVEL_OFFSET)
    ) u_descale (
        .data_i    (in_data),
        .shift_i   (eff_shift),
        .scaled_o  (scaled),
        .scaled_i  (s1_data_q),
        .pix_o     (pix),
        .clamped_o (clamped)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_col_d    = s1_col_q;
        s1_row_d    = s1_row_q;
        col_d       = col_q;
        row_d       = row_q;
        shift_d     = shift_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = scaled;
            s1_col_d   = col_q;
            s1_row_d   = row_q;
            if (block_start) begin
                shift_d = shift_amt;
            end
            if (col_q == COL_W'(ROW_PIX - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_CW'(ROWS_PER_BLOCK - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (s1_take) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s1_take) begin
            if (s1_last_col) begin
                out_valid_d = 1'b1;
                out_row_d   = {pix, pack_q};
                out_last_d  = (s1_row_q == ROW_CW'(ROWS_PER_BLOCK - 1));
            end else begin
                for (int k = 0; k < ROW_PIX - 1; k++) begin
                    if (s1_col_q == COL_W'(k)) begin
                        pack_d[k*PIX_W +: PIX_W] = pix;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            shift_q     <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            col_q       <= col_d;
            row_q       <= row_d;
            shift_q     <= shift_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;

`ifdef DESCALE_SAT_COUNT_EN
    logic [15:0] sat_count_q, sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s1_take && clamped && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_clamped;
    assign unused_clamped = clamped;
`endif
endmodule

// File: tb/tb_idct_descale_packer.sv
// Directed, table-driven bench for idct_descale_packer (sat counter checks
// only when DESCALE_SAT_COUNT_EN is defined).
module tb_idct_descale_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  shift_amt = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_row;
    logic        out_last;
`ifdef DESCALE_SAT_COUNT_EN
    logic        sat_clear = 1'b0;
    logic [15:0] sat_count;
`endif

    typedef struct packed {
        logic [4:0]       sh;
        logic [7:0][31:0] d;
        logic [7:0][7:0]  p;
        logic             last;
    } vec_t;

    vec_t        tbl [18];
    logic [64:0] rows_q [$];
    int          total = 0;
    int          bad = 0;

    idct_descale_packer dut (
        .clk       (clk),
        .rst       (rst),
        .shift_amt (shift_amt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last)
`ifdef DESCALE_SAT_COUNT_EN
       ,.sat_clear (sat_clear),
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rows_q.push_back({out_last, out_row});
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rows_q.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] sh);
        logic rdy;
        int   n;
        in_valid  = 1'b1;
        in_data   = d;
        shift_amt = sh;
        n = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=no_accept exp=accept data=%h", d);
        end
    endtask

    task automatic wait_rows(input int n);
        int c = 0;
        while (rows_q.size() < n && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("row_count", 65'(rows_q.size()), 65'(n));
    endtask

    function automatic logic [63:0] bp_row(input int r);
        logic [7:0][7:0] p;
        for (int k = 0; k < 8; k++) p[k] = 8'(3 * (8 * r + k) + 68);
        return p;
    endfunction

    initial begin
        logic [7:0][31:0] da;
        logic [7:0][7:0]  pa;
        logic [31:0]      bp [24];
        int               acc;
        logic             rdy;

        // ---- table: block sh=0 of -1, block sh=1 of 3 (shift change at row 3 ignored), block sh=5
        for (int r = 0; r < 16; r++) begin
            tbl[r].sh   = (r < 8) ? 5'd0 : ((r < 11) ? 5'd1 : 5'd5);
            tbl[r].last = (r == 7) || (r == 15);
            for (int k = 0; k < 8; k++) begin
                tbl[r].d[k] = (r < 8) ? 32'hFFFF_FFFF : 32'd3;
                tbl[r].p[k] = (r < 8) ? 8'd127 : 8'd130;
            end
        end
        tbl[16].sh = 5'd5; tbl[16].last = 1'b0;
        tbl[16].d = {-32'sd17, -32'sd16, 32'd32, 32'd31, 32'd100000, -32'sd100000, 32'd100, 32'd3};
        tbl[16].p = {8'd127, 8'd128, 8'd129, 8'd129, 8'd255, 8'd0, 8'd131, 8'd128};
        tbl[17].sh = 5'd5; tbl[17].last = 1'b0;
        tbl[17].d = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF};
        tbl[17].p = {8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd0, 8'd255};

        // ---- reset state
        do_reset();
        chk("rst_in_ready", 65'(in_ready), 65'(1));
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_out_row", 65'(out_row), 65'(0));
        chk("rst_out_last", 65'(out_last), 65'(0));

        // ---- single row, shift 3, latency
        out_ready = 1'b1;
        da = {-32'sd4, 32'd255, 32'd7, 32'd0, -32'sd1, 32'd2000, -32'sd2000, 32'd100};
        pa = {8'd128, 8'd160, 8'd129, 8'd128, 8'd128, 8'd255, 8'd0, 8'd141};
        for (int k = 0; k < 8; k++) send(da[k], 5'd3);
        in_valid = 1'b0;
        chk("lat_edge_T", 65'(out_valid), 65'(0));
        @(posedge clk);
        #1;
        chk("lat_edge_T1", 65'(out_valid), 65'(1));
        chk("rowA_pixels", 65'(out_row), 65'(pa));
        chk("rowA_last", 65'(out_last), 65'(0));

        // ---- table-driven blocks at full throughput
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 18; r++)
            for (int k = 0; k < 8; k++) send(tbl[r].d[k], tbl[r].sh);
        in_valid = 1'b0;
        wait_rows(18);
        for (int r = 0; r < 18; r++) begin
            if (r < rows_q.size()) begin
                chk($sformatf("tbl_row%0d", r), 65'(rows_q[r][63:0]), 65'(tbl[r].p));
                chk($sformatf("tbl_last%0d", r), 65'(rows_q[r][64]), 65'(tbl[r].last));
            end
        end

        // ---- backpressure
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) bp[i] = 32'(3 * i - 60);
        acc = 0;
        in_valid = 1'b1;
        shift_amt = 5'd0;
        for (int c = 0; c < 30; c++) begin
            in_data = (acc < 24) ? bp[acc] : 32'd0;
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 65'(acc), 65'(16));
        chk("bp_in_ready_low", 65'(in_ready), 65'(0));
        chk("bp_out_valid", 65'(out_valid), 65'(1));
        chk("bp_row1_held", 65'(out_row), 65'(bp_row(0)));
        chk("bp_row1_last", 65'(out_last), 65'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_swap_valid", 65'(out_valid), 65'(1));
        chk("bp_swap_row2", 65'(out_row), 65'(bp_row(1)));
        chk("bp_in_ready_back", 65'(in_ready), 65'(1));
        out_ready = 1'b1;
        for (int i = 16; i < 24; i++) send(bp[i], 5'd0);
        in_valid = 1'b0;
        wait_rows(3);
        for (int r = 0; r < 3; r++) begin
            if (r < rows_q.size())
                chk($sformatf("bp_seq_row%0d", r), rows_q[r], {1'b0, bp_row(r)});
        end

        // ---- reset mid-row
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(32'd1000, 5'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) send(32'd0, 5'd2);
        in_valid = 1'b0;
        wait_rows(1);
        if (rows_q.size() > 0)
            chk("rst_mid_row", rows_q[0], {1'b0, 64'h8080_8080_8080_8080});

`ifdef DESCALE_SAT_COUNT_EN
        // ---- saturation counter
        do_reset();
        out_ready = 1'b1;
        da = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1000, -32'sd200, 32'd300};
        for (int k = 0; k < 8; k++) send(da[k], 5'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sat_count_3", 65'(sat_count), 65'(3));
        send(32'd500, 5'd0);
        in_valid = 1'b0;
        sat_clear = 1'b1;
        @(posedge clk);
        #1;
        sat_clear = 1'b0;
        chk("sat_clear_wins", 65'(sat_count), 65'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
